// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue stage: op codes, RV64D decode fields,
// FSM state encoding, captured-result payload and latency helpers.
package fpu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned PERF_W = 32;

    typedef logic [OP_W-1:0] fpu_op_t;

    localparam fpu_op_t FPU_OP_ADD    = 3'b000;
    localparam fpu_op_t FPU_OP_SUB    = 3'b001;
    localparam fpu_op_t FPU_OP_MUL    = 3'b010;
    localparam fpu_op_t FPU_OP_DIV    = 3'b011;
    localparam fpu_op_t FPU_OP_SQRT   = 3'b100;
    localparam fpu_op_t FPU_OP_CVT_LD = 3'b101;
    localparam fpu_op_t FPU_OP_CVT_DL = 3'b110;
    localparam fpu_op_t FPU_OP_INV    = 3'b111;

    localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;
    localparam logic [1:0] FMT_D        = 2'b01;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_CVT_LD = 5'b11000;
    localparam logic [4:0] F5_CVT_DL = 5'b11010;
    // rs2 selector that picks the 64-bit integer (L) variant of the converts
    localparam logic [4:0] RS2_CVT_L = 5'b00010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [REG_W-1:0] rd;
        logic             is_int;
        logic             illegal;
    } result_t;

    function automatic int unsigned lat_clamp(input int lat);
        return (lat < 1) ? 32'd1 : unsigned'(lat);
    endfunction

    function automatic int unsigned lat_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpu_issue_stage_if.sv
// Instruction-in / result-out handshake bundle of the FPU issue stage.
interface fpu_issue_stage_if;
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [INSN_W-1:0] instruction;
    logic [XLEN-1:0]   in1;
    logic [XLEN-1:0]   in2;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_is_int;
    logic              out_illegal;

    modport master (
        output in_valid, instruction, in1, in2, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_is_int, out_illegal
    );

    modport slave (
        input  in_valid, instruction, in1, in2, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_is_int, out_illegal
    );
endinterface

// File: rtl/fpu_cntrl.sv
// Combinational RV64D OP-FP decoder: maps an instruction word to the FPU op,
// returning FPU_OP_INV for anything outside the supported double-precision set.
module fpu_cntrl
    import fpu_pkg::*;
(
    input  logic [INSN_W-1:0] instruction,
    output fpu_op_t           op_c
);
    logic [6:0] opcode;
    logic [1:0] fmt;
    logic [4:0] funct5;
    logic [4:0] rs2;
    logic       unused_fields;

    assign opcode        = instruction[6:0];
    assign fmt           = instruction[26:25];
    assign funct5        = instruction[31:27];
    assign rs2           = instruction[24:20];
    assign unused_fields = ^instruction[19:7];

    always_comb begin
        op_c = FPU_OP_INV;
        if (opcode == OPCODE_OP_FP && fmt == FMT_D) begin
            case (funct5)
                F5_ADD:    op_c = FPU_OP_ADD;
                F5_SUB:    op_c = FPU_OP_SUB;
                F5_MUL:    op_c = FPU_OP_MUL;
                F5_DIV:    op_c = FPU_OP_DIV;
                F5_SQRT:   op_c = FPU_OP_SQRT;
                F5_CVT_LD: if (rs2 == RS2_CVT_L) op_c = FPU_OP_CVT_LD;
                F5_CVT_DL: if (rs2 == RS2_CVT_L) op_c = FPU_OP_CVT_DL;
                default:   op_c = FPU_OP_INV;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_stage.sv
// Sequential wrapper that holds op/operands stable for an op-specific number of
// cycles into a combinational FPU and captures the result. Optional counters: FPU_PERF_CNT_EN.
module fpu_issue_stage
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 12,
    parameter int LAT_SQRT   = 16,
    parameter int LAT_CVT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_issue_stage_if.slave  bus,
    output fpu_op_t           fpu_op,
    output logic [XLEN-1:0]   fpu_in1,
    output logic [XLEN-1:0]   fpu_in2,
    input  logic [XLEN-1:0]   fpu_out
`ifdef FPU_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_ops,
    output logic [PERF_W-1:0] perf_stall
`endif
);
    localparam int unsigned L_ADDSUB = lat_clamp(LAT_ADDSUB);
    localparam int unsigned L_MUL    = lat_clamp(LAT_MUL);
    localparam int unsigned L_DIV    = lat_clamp(LAT_DIV);
    localparam int unsigned L_SQRT   = lat_clamp(LAT_SQRT);
    localparam int unsigned L_CVT    = lat_clamp(LAT_CVT);
    localparam int unsigned L_MAX    = lat_max(lat_max(lat_max(L_ADDSUB, L_MUL),
                                                       lat_max(L_DIV, L_SQRT)), L_CVT);
    localparam int unsigned CNT_W    = $clog2(L_MAX) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rdy;
    logic             vld;
    result_t          res;
    fpu_op_t          dec_op_c;
    int unsigned      lat_sel_c;

    fpu_cntrl u_dec (
        .instruction (bus.instruction),
        .op_c        (dec_op_c)
    );

    assign bus.in_ready    = rdy;
    assign bus.out_valid   = vld;
    assign bus.out_data    = res.data;
    assign bus.out_rd      = res.rd;
    assign bus.out_is_int  = res.is_int;
    assign bus.out_illegal = res.illegal;

    // Hold time for the op being accepted
    always_comb begin
        lat_sel_c = L_ADDSUB;
        case (dec_op_c)
            FPU_OP_ADD, FPU_OP_SUB:       lat_sel_c = L_ADDSUB;
            FPU_OP_MUL:                   lat_sel_c = L_MUL;
            FPU_OP_DIV:                   lat_sel_c = L_DIV;
            FPU_OP_SQRT:                  lat_sel_c = L_SQRT;
            FPU_OP_CVT_LD, FPU_OP_CVT_DL: lat_sel_c = L_CVT;
            default:                      lat_sel_c = 32'd1;
        endcase
    end

    // IDLE -> EXEC -> DONE -> IDLE; illegal ops skip EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdy     <= 1'b1;
            vld     <= 1'b0;
            res     <= '0;
            fpu_op  <= FPU_OP_INV;
            fpu_in1 <= '0;
            fpu_in2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        fpu_op     <= dec_op_c;
                        fpu_in1    <= bus.in1;
                        fpu_in2    <= bus.in2;
                        res.rd     <= bus.instruction[11:7];
                        res.is_int <= (dec_op_c == FPU_OP_CVT_LD);
                        cnt        <= CNT_W'(lat_sel_c - 32'd1);
                        rdy        <= 1'b0;
                        if (dec_op_c == FPU_OP_INV) begin
                            res.data    <= '0;
                            res.illegal <= 1'b1;
                            vld         <= 1'b1;
                            state       <= DONE;
                        end else begin
                            res.illegal <= 1'b0;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        res.data <= fpu_out;
                        vld      <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    vld   <= 1'b0;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FPU_PERF_CNT_EN
    // Completed result handshakes and cycles where a request was turned away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (state == DONE && bus.out_ready) perf_ops <= perf_ops + PERF_W'(1);
            if (bus.in_valid && !rdy)           perf_stall <= perf_stall + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Scoreboard bench for fpu_issue_stage with a behavioural double-precision FPU attached.
module tb_fpu_issue_stage;

    localparam logic [63:0] D49   = 64'h4048800000000000;
    localparam logic [63:0] D13_5 = 64'h402b000000000000;
    localparam logic [63:0] D27   = 64'h403B000000000000;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        is_int;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  fpu_op;
    logic [63:0] fpu_in1, fpu_in2, fpu_out;
`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    fpu_issue_stage_if bus ();

    fpu_issue_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .fpu_op  (fpu_op),
        .fpu_in1 (fpu_in1),
        .fpu_in2 (fpu_in2),
        .fpu_out (fpu_out)
`ifdef FPU_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] fpu_model(input logic [2:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        real ra, rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        case (op)
            3'b000:  return $realtobits(ra + rb);
            3'b001:  return $realtobits(ra - rb);
            3'b010:  return $realtobits(ra * rb);
            3'b011:  return $realtobits(ra / rb);
            3'b100:  return $realtobits($sqrt(ra));
            3'b101:  return 64'(longint'(ra));
            3'b110:  return $realtobits(real'($signed(a)));
            default: return 64'h0;
        endcase
    endfunction

    assign fpu_out = fpu_model(fpu_op, fpu_in1, fpu_in2);

    task automatic chk(input string tag, input string field, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h (cycle %0d)", tag, field, act, exp, cyc);
        end
    endtask

    task automatic issue(input string name, input logic [31:0] w, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] op, input logic [63:0] data,
                         input logic [4:0] rd, input logic is_int, input logic ill,
                         input int lat, input bit push, output int stalls);
        exp_t e;
        stalls = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.instruction = w;
        bus.in1         = a;
        bus.in2         = b;
        while (!bus.in_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (!bus.in_ready) begin
            chk(name, "accept_timeout", 64'(stalls), 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e.name = name; e.op = op; e.a = a; e.b = b; e.data = data; e.rd = rd;
        e.is_int = is_int; e.ill = ill; e.lat = lat; e.acc = cyc;
        if (push) q.push_back(e);
        chk(name, "fpu_op_at_accept", 64'(fpu_op), 64'(op));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", "pending", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops on each new result and checks it is held stable while pending
    initial begin : monitor
        exp_t cur;
        logic prev;
        bit   has_cur;
        prev = 1'b0;
        has_cur = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev = 1'b0;
                has_cur = 1'b0;
            end else begin
                if (bus.out_valid && !prev) begin
                    if (q.size() == 0) begin
                        chk("monitor", "unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                        has_cur = 1'b0;
                    end else begin
                        cur = q.pop_front();
                        has_cur = 1'b1;
                        chk(cur.name, "out_data", bus.out_data, cur.data);
                        chk(cur.name, "out_rd", 64'(bus.out_rd), 64'(cur.rd));
                        chk(cur.name, "out_is_int", 64'(bus.out_is_int), 64'(cur.is_int));
                        chk(cur.name, "out_illegal", 64'(bus.out_illegal), 64'(cur.ill));
                        chk(cur.name, "latency", 64'(cyc - cur.acc), 64'(cur.lat));
                        chk(cur.name, "in_ready_in_done", 64'(bus.in_ready), 64'd0);
                    end
                end else if (bus.out_valid) begin
                    if (has_cur) chk(cur.name, "out_data_held", bus.out_data, cur.data);
                end else if (q.size() != 0) begin
                    chk(q[0].name, "fpu_op_held", 64'(fpu_op), 64'(q[0].op));
                    chk(q[0].name, "fpu_in1_held", fpu_in1, q[0].a);
                    chk(q[0].name, "fpu_in2_held", fpu_in2, q[0].b);
                end
                prev = bus.out_valid;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int st;
        int n;
`ifdef FPU_PERF_CNT_EN
        logic [31:0] snap_stall;
`endif
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.instruction = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset", "in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset", "out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset", "fpu_op", 64'(fpu_op), 64'd7);
        chk("reset", "out_data", bus.out_data, 64'd0);
        chk("reset", "out_rd", 64'(bus.out_rd), 64'd0);
        chk("reset", "flags", 64'({bus.out_is_int, bus.out_illegal}), 64'd0);
        chk("reset", "fpu_in1", fpu_in1, 64'd0);
        rst_n = 1'b1;

        issue("fadd", 32'h023170d3, D49, D13_5, 3'b000, 64'h404F400000000000, 5'd1, 1'b0, 1'b0, 2, 1, st);
        issue("fsub", 32'h0a3170d3, D49, D13_5, 3'b001, 64'h4041C00000000000, 5'd1, 1'b0, 1'b0, 2, 1, st);
        drain();

        // Writeback backpressure on fmul
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue("fmul", 32'h1293fad3, D49, D13_5, 3'b010, 64'h4084AC0000000000, 5'd21, 1'b0, 1'b0, 3, 1, st);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 50);
        chk("fmul_bp", "out_valid_seen", 64'(bus.out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("fmul_bp", "out_valid_held", 64'(bus.out_valid), 64'd1);
            chk("fmul_bp", "in_ready_low", 64'(bus.in_ready), 64'd0);
            chk("fmul_bp", "out_data_held", bus.out_data, 64'h4084AC0000000000);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fmul_bp", "in_ready_after_release", 64'(bus.in_ready), 64'd1);
        chk("fmul_bp", "out_valid_after_release", 64'(bus.out_valid), 64'd0);

        // fdiv with the next request held valid behind it
`ifdef FPU_PERF_CNT_EN
        snap_stall = perf_stall;
`endif
        issue("fdiv", 32'h1af87f53, D27, D13_5, 3'b011, 64'h4000000000000000, 5'd30, 1'b0, 1'b0, 12, 1, st);
        issue("fcvt_l_d", 32'hc225f9d3, D49, D13_5, 3'b101, 64'h31, 5'd19, 1'b1, 1'b0, 1, 1, st);
        chk("fdiv_hold", "blocked_cycles", 64'(st), 64'd13);
`ifdef FPU_PERF_CNT_EN
        chk("fdiv_hold", "perf_stall_delta", 64'(perf_stall - snap_stall), 64'd13);
`endif

        issue("illegal", 32'hF8000053, D49, D13_5, 3'b111, 64'h0, 5'd0, 1'b0, 1'b1, 0, 1, st);
        issue("bad_fmt", 32'h003170d3, D49, D13_5, 3'b111, 64'h0, 5'd1, 1'b0, 1'b1, 0, 1, st);
        issue("bad_rs2", 32'hc215f9d3, D49, D13_5, 3'b111, 64'h0, 5'd19, 1'b0, 1'b1, 0, 1, st);
        issue("fcvt_d_l", 32'hd22502d3, 64'd10, D13_5, 3'b110, 64'h4024000000000000, 5'd5, 1'b0, 1'b0, 1, 1, st);
        drain();
`ifdef FPU_PERF_CNT_EN
        chk("perf", "perf_ops", 64'(perf_ops), 64'd9);
`endif

        // Reset in the middle of fsqrt: the op must vanish
        issue("fsqrt_abort", 32'h5a01fbd3, D49, D13_5, 3'b100, 64'h0, 5'd23, 1'b0, 1'b0, 16, 0, st);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset", "out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_reset", "fpu_op", 64'(fpu_op), 64'd7);
        chk("mid_reset", "in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FPU_PERF_CNT_EN
        chk("mid_reset", "perf_cleared", 64'({perf_ops, perf_stall}), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        chk("post_reset", "out_valid_quiet", 64'(bus.out_valid), 64'd0);

        issue("fsqrt", 32'h5a01fbd3, D49, D13_5, 3'b100, 64'h401C000000000000, 5'd23, 1'b0, 1'b0, 16, 1, st);
        drain();
`ifdef FPU_PERF_CNT_EN
        chk("perf", "perf_ops_after_reset", 64'(perf_ops), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
